vote_session_ctrl: RTL
======================

VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter WINDOW, default 16: maximum COLLECT duration in clock cycles, legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that opens a voting session; honoured only in IDLE.
REQ-005 abort  input  1  cancels the session from any non-IDLE state.
REQ-006 vote_valid  input  4  per-voter strobe; bit i qualifies vote_val[i].
REQ-007 vote_val  input  4  per-voter ballot: 1 = yes, 0 = no.
REQ-008 ballot  output  4  registered ballot vector driven to the voter datapath I[3:0].
REQ-009 result_in  input  3  combinational verdict returned from voter datapath O[3:1].
REQ-010 result_out  output  3  registered verdict of the last completed session.
REQ-011 voted  output  4  mask of voters already counted this session.
REQ-012 busy  output  1  high in COLLECT and EVAL.
REQ-013 done  output  1  one-cycle pulse when result_out updates.
REQ-014 timeout  output  1  sticky flag: last session closed by window expiry with at least one voter missing.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, COLLECT, EVAL, DONE.
REQ-016 IDLE -> COLLECT on start=1; same edge clears ballot, voted, timeout and the window counter.
REQ-017 In COLLECT, for each i with vote_valid[i]=1 and voted[i]=0: ballot[i] <= vote_val[i] and voted[i] <= 1.
REQ-018 A repeat vote_valid[i] once voted[i]=1 SHALL be ignored; first vote wins.
REQ-019 Several voters in one cycle SHALL all be accepted on that edge.
REQ-020 Window counter: 8 bits; increments every COLLECT cycle; 0 on COLLECT entry.
REQ-021 COLLECT -> EVAL when the next voted value equals 4'b1111, or the counter equals WINDOW-1.
REQ-022 On expiry, missing voters keep ballot bit 0 (counted as no) and timeout <= 1.
REQ-023 Last missing vote arriving on the expiry cycle: vote accepted, timeout stays 0.
REQ-024 EVAL lasts one cycle: ballot stable, result_out <= result_in at end of EVAL.
REQ-025 EVAL -> DONE; DONE asserts done=1 for one cycle, then -> IDLE.
REQ-026 result_out, ballot, voted and timeout SHALL hold their values in IDLE until the next accepted start.
REQ-027 start outside IDLE SHALL be ignored with no state change.
REQ-028 abort in COLLECT/EVAL/DONE -> IDLE next edge: done not pulsed, result_out unchanged, ballot and voted cleared.
REQ-029 abort and start together in IDLE: start wins, because abort has no effect in IDLE.
REQ-030 Latency from the last vote edge to the done pulse SHALL be 2 cycles: EVAL, then DONE.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, with ballot=0, voted=0, result_out=0, done=0, busy=0, timeout=0 and counter=0, independent of clk.
REQ-032 Reset mid-session SHALL discard the session without a done pulse; operation resumes on the first start after rst_n rises.

Verification
REQ-033 start, then votes 1,1,1,0 in the same cycle -> ballot=4'b0111, EVAL next cycle, done one cycle later, result_out equals the voter verdict for 0111.
REQ-034 start, votes only from voters 0 and 2 (yes), WINDOW=16 -> exit at counter 15, ballot=4'b0101, timeout=1, done pulse.
REQ-035 voter 1 votes yes, then no two cycles later -> ballot[1] stays 1.
REQ-036 abort on the third COLLECT cycle after a completed session -> IDLE, no done, result_out retains its prior value.
REQ-037 rst_n low mid-COLLECT -> all outputs 0 asynchronously; a start after release runs a clean session.
REQ-038 fourth vote arrives on the counter=WINDOW-1 cycle -> timeout=0, voted=4'b1111.

Source files
------------

// File: rtl/vote_session_ctrl.sv
// Purpose : four-voter ballot session controller. It collects one vote per voter within a
//           bounded window, presents the ballot to the voter datapath, and latches the verdict.
// Latency : the last accepted vote is followed by EVAL (1 cycle), then the done pulse in DONE (1 cycle).
// Backpr. : none; votes are strobes. Repeat strobes from a voter who is already counted are dropped.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start / abort       open a session (IDLE only) / cancel a session (any non-IDLE state)
//   vote_valid/vote_val per-voter strobe and ballot (1 = yes)
//   ballot              registered ballot vector to the voter datapath
//   result_in           combinational verdict from the voter datapath
//   result_out          verdict of the last completed session
//   voted               voters already counted this session
//   busy / done         COLLECT or EVAL / one-cycle completion pulse
//   timeout             sticky: the last session expired with a voter missing
module vote_session_ctrl #(
   parameter int unsigned WINDOW = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] vote_valid,
   input  logic [3:0] vote_val,
   output logic [3:0] ballot,
   input  logic [2:0] result_in,
   output logic [2:0] result_out,
   output logic [3:0] voted,
   output logic       busy,
   output logic       done,
   output logic       timeout
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_EVAL    = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);

   logic [1:0] state;
   logic [7:0] win_cnt;

   logic [3:0] accept;
   logic [3:0] voted_nxt;
   logic [3:0] ballot_nxt;
   logic       all_in;
   logic       win_last;

   // Only the first strobe from each voter is taken. Later strobes are masked by voted.
   assign accept     = vote_valid & ~voted;
   assign voted_nxt  = voted | accept;
   assign ballot_nxt = (ballot & ~accept) | (vote_val & accept);
   assign all_in     = (voted_nxt == 4'b1111);
   assign win_last   = (win_cnt == WIN_LAST);

   assign busy = (state == ST_COLLECT) || (state == ST_EVAL);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         win_cnt    <= 8'd0;
         ballot     <= 4'd0;
         voted      <= 4'd0;
         result_out <= 3'd0;
         timeout    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // abort has no meaning here, so start alone decides
               if (start) begin
                  state   <= ST_COLLECT;
                  win_cnt <= 8'd0;
                  ballot  <= 4'd0;
                  voted   <= 4'd0;
                  timeout <= 1'b0;
               end
            end
            ST_COLLECT: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  win_cnt <= 8'd0;
                  ballot  <= 4'd0;
                  voted   <= 4'd0;
               end else begin
                  ballot  <= ballot_nxt;
                  voted   <= voted_nxt;
                  win_cnt <= win_cnt + 8'd1;
                  // A full house on the expiry cycle counts as complete, so no timeout.
                  if (all_in) begin
                     state <= ST_EVAL;
                  end else if (win_last) begin
                     state   <= ST_EVAL;
                     timeout <= 1'b1;
                  end
               end
            end
            ST_EVAL: begin
               if (abort) begin
                  state  <= ST_IDLE;
                  ballot <= 4'd0;
                  voted  <= 4'd0;
               end else begin
                  result_out <= result_in;
                  state      <= ST_DONE;
               end
            end
            default: begin // ST_DONE
               state <= ST_IDLE;
               if (abort) begin
                  ballot <= 4'd0;
                  voted  <= 4'd0;
               end
            end
         endcase
      end
   end

endmodule
